// File: rtl/muxreg_load_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : muxreg_load_arbiter
// Purpose  : Arbitrates two producers (A = D0 leg, B = D1 leg) onto one shared
//            WIDTH-bit mux-select load register. It generates the select,
//            load-enable and synchronous-clear controls for that register and
//            presents the held word to a single consumer through a 1-deep
//            valid/ready buffer.
// Ports    : CK        clock, all state on rising edge
//            CD        synchronous active-high reset (dominates all inputs)
//            en        global load enable, 0 freezes all state
//            clr       synchronous flush of the held word (ignores en)
//            a_valid/a_data/a_ready   source A handshake
//            b_valid/b_data/b_ready   source B handshake
//            q/q_valid/q_src/q_ready  held word, valid, source (0=A, 1=B)
//            cnt_clr, cnt_a, cnt_b    transfer counters (MUXREG_ARB_STATS_EN)
// Params   : WIDTH      data width (1..64)
//            FIXED_PRIO 0 = round-robin on conflict, 1 = A always wins
// Macro    : MUXREG_ARB_STATS_EN adds the 16-bit per-source transfer counters.
// Revision : 1.0 - initial release
// ============================================================================
module muxreg_load_arbiter #(
  parameter int WIDTH      = 8,
  parameter int FIXED_PRIO = 0
) (
  input  logic             CK,
  input  logic             CD,
  input  logic             en,
  input  logic             clr,
  input  logic             a_valid,
  input  logic [WIDTH-1:0] a_data,
  output logic             a_ready,
  input  logic             b_valid,
  input  logic [WIDTH-1:0] b_data,
  output logic             b_ready,
  output logic [WIDTH-1:0] q,
  output logic             q_valid,
  output logic             q_src,
  input  logic             q_ready
`ifdef MUXREG_ARB_STATS_EN
  ,
  input  logic             cnt_clr,
  output logic [15:0]      cnt_a,
  output logic [15:0]      cnt_b
`endif
);

  typedef enum logic [0:0] {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] w_q_nxt;
  logic             r_src;
  logic             w_src_nxt;
  logic             r_rr;
  logic             w_rr_nxt;

  logic             w_can_load;
  logic             w_contest_a;
  logic             w_a_wins;
  logic             w_a_take;
  logic             w_b_take;

  // A load is possible only when the buffer is empty or being drained in the
  // same cycle; CD is folded in so no ready is advertised while in reset.
  assign w_can_load = ~CD & en & ~clr & ((r_state == EMPTY) | q_ready);

  // Winner of a contested cycle (both sources valid).
  if (FIXED_PRIO != 0) begin : g_fixed_prio
    assign w_contest_a = 1'b1;
  end else begin : g_round_robin
    assign w_contest_a = ~r_rr;
  end

  assign w_a_wins = a_valid & (~b_valid | w_contest_a);
  assign w_a_take = w_can_load & w_a_wins;
  assign w_b_take = w_can_load & b_valid & ~w_a_wins;

  assign a_ready = w_a_take;
  assign b_ready = w_b_take;

  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_src_nxt   = r_src;
    w_rr_nxt    = r_rr;
    if (clr) begin
      // Flush wins over any consumer handshake; rr is deliberately kept.
      w_state_nxt = EMPTY;
      w_q_nxt     = '0;
      w_src_nxt   = 1'b0;
    end else if (en) begin
      if (w_a_take | w_b_take) begin
        w_state_nxt = FULL;
        w_q_nxt     = w_b_take ? b_data : a_data;
        w_src_nxt   = w_b_take;
        // Only contested grants move the pointer, toward the loser.
        if (a_valid & b_valid) begin
          w_rr_nxt = w_a_take;
        end
      end else if ((r_state == FULL) & q_ready) begin
        w_state_nxt = EMPTY;
      end
    end
  end

  always_ff @(posedge CK) begin
    if (CD) begin
      r_state <= EMPTY;
      r_q     <= '0;
      r_src   <= 1'b0;
      r_rr    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_src   <= w_src_nxt;
      r_rr    <= w_rr_nxt;
    end
  end

  assign q       = r_q;
  assign q_valid = (r_state == FULL);
  assign q_src   = r_src;

`ifdef MUXREG_ARB_STATS_EN
  logic [15:0] r_cnt_a;
  logic [15:0] r_cnt_b;

  // Counters wrap naturally; cnt_clr outranks an increment in the same cycle.
  always_ff @(posedge CK) begin
    if (CD | cnt_clr) begin
      r_cnt_a <= '0;
      r_cnt_b <= '0;
    end else begin
      if (w_a_take) begin
        r_cnt_a <= r_cnt_a + 16'd1;
      end
      if (w_b_take) begin
        r_cnt_b <= r_cnt_b + 16'd1;
      end
    end
  end

  assign cnt_a = r_cnt_a;
  assign cnt_b = r_cnt_b;
`endif

endmodule
`default_nettype wire
